// File: rtl/ram_arbiter_pkg.sv
// Shared bus widths, enable levels and ownership encoding for the data-RAM arbiter.
// Imported by the arbiter top and its wait counter.
package ram_arbiter_pkg;

  localparam int   REG_BUS_W       = 32;
  localparam int   INST_ADDR_BUS_W = 32;
  localparam logic CHIP_ENABLE     = 1'b1;
  localparam logic CHIP_DISABLE    = 1'b0;
  localparam logic WRITE_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE   = 1'b0;

  typedef enum logic {
    CPU_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } owner_e;

  // Bits needed to hold 0..max_val-1 (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/ram_arbiter_wait_counter.sv
// Saturating counter of denied host cycles; sat flag is registered alongside the count
// and is high once the count reaches MAX-1.
module arb_wait_counter
  import ram_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat_flag
);

  localparam logic [W-1:0] SAT_VAL     = W'(MAX - 1);
  localparam logic         SAT_AT_ZERO = (MAX == 1);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         sat_r;

  // Next count: clear wins, then increment until saturated.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {W{1'b0}};
    end else if (inc && !sat_r) begin
      cnt_nxt_s = cnt_r + W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and saturation flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
      sat_r <= SAT_AT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
      sat_r <= (cnt_nxt_s == SAT_VAL);
    end
  end

  assign sat_flag = sat_r;

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: CPU owns the port by default, host gets one-cycle
// single-beat accesses, forced through after MAX_WAIT-1 denied cycles of a busy CPU.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = INST_ADDR_BUS_W,
  parameter int DATA_W   = REG_BUS_W,
  parameter int SEL_W    = DATA_W / 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [SEL_W-1:0]  host_sel_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic [DATA_W-1:0] host_data_o,
  output logic              host_ack_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  owner_e            owner_r;
  logic              host_ack_r;
  logic [DATA_W-1:0] host_data_r;
  logic              wait_sat_s;
  logic              host_pending_s;
  logic              grant_s;
  logic              wait_inc_s;
  logic              wait_clr_s;

  // The request is ignored during the ack cycle so the CPU keeps every other cycle.
  assign host_pending_s = (owner_r == CPU_OWN) && host_req_i && !host_ack_r;
  assign grant_s        = host_pending_s && (!cpu_ce_i || wait_sat_s);
  assign wait_inc_s     = host_pending_s && !grant_s;
  assign wait_clr_s     = grant_s || (owner_r == HOST_OWN);

  arb_wait_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (wait_inc_s),
    .clr      (wait_clr_s),
    .sat_flag (wait_sat_s)
  );

  // Ownership FSM with registered host handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= CPU_OWN;
      host_ack_r  <= 1'b0;
      host_data_r <= {DATA_W{1'b0}};
    end else begin
      case (owner_r)
        CPU_OWN: begin
          host_ack_r <= 1'b0;
          if (grant_s) begin
            owner_r <= HOST_OWN;
          end else begin
            owner_r <= CPU_OWN;
          end
        end
        HOST_OWN: begin
          owner_r    <= CPU_OWN;
          host_ack_r <= 1'b1;
          if (!host_we_i) begin
            host_data_r <= ram_data_i;
          end else begin
            host_data_r <= host_data_r;
          end
        end
        default: begin
          owner_r    <= CPU_OWN;
          host_ack_r <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux; everything is forced idle while reset is asserted.
  always_comb begin
    ram_ce_o    = CHIP_DISABLE;
    ram_we_o    = WRITE_DISABLE;
    ram_addr_o  = {ADDR_W{1'b0}};
    ram_sel_o   = {SEL_W{1'b0}};
    ram_data_o  = {DATA_W{1'b0}};
    cpu_data_o  = {DATA_W{1'b0}};
    cpu_stall_o = 1'b0;
    if (rst) begin
      ram_ce_o = CHIP_DISABLE;
    end else begin
      case (owner_r)
        HOST_OWN: begin
          ram_ce_o    = CHIP_ENABLE;
          ram_we_o    = host_we_i ? WRITE_ENABLE : WRITE_DISABLE;
          ram_addr_o  = host_addr_i;
          ram_sel_o   = host_sel_i;
          ram_data_o  = host_data_i;
          cpu_stall_o = cpu_ce_i;
        end
        CPU_OWN: begin
          ram_ce_o   = cpu_ce_i;
          ram_we_o   = cpu_we_i;
          ram_addr_o = cpu_addr_i;
          ram_sel_o  = cpu_sel_i;
          ram_data_o = cpu_data_i;
          cpu_data_o = ram_data_i;
        end
        default: begin
          ram_ce_o = CHIP_DISABLE;
        end
      endcase
    end
  end

  assign host_ack_o  = host_ack_r;
  assign host_data_o = host_data_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a cycle-level reference model
// of the sharing rules and a golden copy of the RAM contents.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic          cpu_ce_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [SW-1:0] cpu_sel_i;
  logic [DW-1:0] cpu_data_i, cpu_data_o;
  logic          cpu_stall_o;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [SW-1:0] host_sel_i;
  logic [DW-1:0] host_data_i, host_data_o;
  logic          host_ack_o;
  logic          ram_ce_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [SW-1:0] ram_sel_o;
  logic [DW-1:0] ram_data_o, ram_data_i;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_sel_i(host_sel_i), .host_data_i(host_data_i), .host_data_o(host_data_o),
    .host_ack_o(host_ack_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 32'hCAFE_0004;
    if (i == 8) return 32'h1234_5678;
    if (i == 16) return 32'h5566_7788;
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[7:2]);
  endfunction

  // RAM device: combinational read, byte-selected write on posedge.
  logic [DW-1:0] mem [0:63];
  logic          mem_load;
  assign ram_data_i = mem[ram_addr_o[7:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ram_ce_o && ram_we_o) begin
      mem[ram_addr_o[7:2]] <= merge(mem[ram_addr_o[7:2]], ram_data_o, ram_sel_o);
    end
  end

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: golden RAM plus who holds the RAM in the current cycle.
  logic [DW-1:0] gmem [0:63];
  bit            m_host_slot;
  bit            m_ack;
  int            m_denied;
  logic [DW-1:0] m_rdata;
  bit            prev_ack;
  int            stall_cnt;

  task automatic model_reset();
    m_host_slot = 1'b0;
    m_ack       = 1'b0;
    m_denied    = 0;
    m_rdata     = '0;
    prev_ack    = 1'b0;
  endtask

  task automatic model_update();
    bit grant;
    if (m_host_slot) begin
      if (!host_we_i) m_rdata = gmem[widx(host_addr_i)];
      else gmem[widx(host_addr_i)] = merge(gmem[widx(host_addr_i)], host_data_i, host_sel_i);
      m_host_slot = 1'b0;
      m_ack       = 1'b1;
      m_denied    = 0;
    end else begin
      grant = host_req_i && !m_ack && (!cpu_ce_i || m_denied >= MW - 1);
      if (cpu_ce_i && cpu_we_i)
        gmem[widx(cpu_addr_i)] = merge(gmem[widx(cpu_addr_i)], cpu_data_i, cpu_sel_i);
      if (grant) m_denied = 0;
      else if (host_req_i && !m_ack && m_denied < MW - 1) m_denied++;
      m_host_slot = grant;
      m_ack       = 1'b0;
    end
  endtask

  task automatic check_comb();
    if (m_host_slot) begin
      check_val("ram_ce", ram_ce_o, 1'b1);
      check_val("ram_we", ram_we_o, host_we_i);
      check_val("ram_addr", ram_addr_o, host_addr_i);
      check_val("ram_sel", ram_sel_o, host_sel_i);
      check_val("ram_wdata", ram_data_o, host_data_i);
      check_val("cpu_stall", cpu_stall_o, cpu_ce_i);
      check_val("cpu_rdata", cpu_data_o, '0);
    end else begin
      check_val("ram_ce", ram_ce_o, cpu_ce_i);
      check_val("ram_we", ram_we_o, cpu_we_i);
      check_val("ram_addr", ram_addr_o, cpu_addr_i);
      check_val("ram_sel", ram_sel_o, cpu_sel_i);
      check_val("ram_wdata", ram_data_o, cpu_data_i);
      check_val("cpu_stall", cpu_stall_o, 1'b0);
      check_val("cpu_rdata", cpu_data_o, gmem[widx(cpu_addr_i)]);
    end
    if (cpu_stall_o) stall_cnt++;
  endtask

  task automatic check_reg();
    check_val("host_ack", host_ack_o, m_ack);
    check_val("host_rdata", host_data_o, m_rdata);
    check_val("ack_not_b2b", host_ack_o && prev_ack, 1'b0);
    prev_ack = host_ack_o;
  endtask

  // One cycle: entered just after a negedge with inputs already driven.
  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_update();
    #1 check_reg();
    @(negedge clk);
  endtask

  task automatic host_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] sel, input bit cpu_busy, output int lat);
    bit done;
    host_req_i  = 1'b1;
    host_we_i   = we;
    host_addr_i = addr;
    host_data_i = data;
    host_sel_i  = sel;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      cpu_ce_i   = cpu_busy;
      cpu_we_i   = 1'b0;
      cpu_addr_i = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
      step();
      lat++;
      if (host_ack_o) done = 1'b1;
    end
    check_val("txn_done", done, 1'b1);
  endtask

  int lat;
  bit h_busy;
  int h_lat;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stall_cnt = 0;
    mem_load  = 1'b1;
    for (int i = 0; i < 64; i++) gmem[i] = init_word(i);
    model_reset();
    rst = 1'b1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0; cpu_sel_i = 4'hF; cpu_data_i = 32'h0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = 32'h0; host_sel_i = 4'hF;
    host_data_i = 32'h0;

    // Reset state, with CPU inputs active to show the port is gated.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_ram_ce", ram_ce_o, 1'b0);
    check_val("rst_ram_we", ram_we_o, 1'b0);
    check_val("rst_stall", cpu_stall_o, 1'b0);
    check_val("rst_cpu_rdata", cpu_data_o, '0);
    check_val("rst_ack", host_ack_o, 1'b0);
    check_val("rst_host_rdata", host_data_o, '0);
    rst = 1'b0;
    mem_load = 1'b0;
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    @(negedge clk);

    // Idle CPU, host read of 0x20.
    stall_cnt = 0;
    host_txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat);
    check_val("idle_lat", lat, 2);
    check_val("idle_rdata", host_data_o, 32'h1234_5678);
    check_val("idle_no_stall", stall_cnt, 0);
    host_req_i = 1'b0;
    step();

    // Busy CPU: host forced through after the starvation limit.
    stall_cnt = 0;
    host_txn(1'b0, 32'h24, 32'h0, 4'hF, 1'b1, lat);
    check_val("busy_lat", lat, MW + 1);
    check_val("busy_stall_cycles", stall_cnt, 1);
    host_req_i = 1'b0;
    cpu_ce_i   = 1'b1;
    step();

    // Host request held for 6 accesses: acks spaced, never consecutive.
    cpu_ce_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      host_txn(1'b0, 32'(k * 4), 32'h0, 4'hF, 1'b0, lat);
      check_val("b2b_lat", lat, (k == 0) ? 2 : 3);
      check_val("b2b_rdata", host_data_o, init_word(k));
    end
    host_req_i = 1'b0;
    step();

    // CPU partial write then host read merges byte lanes.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h40; cpu_sel_i = 4'b0011;
    cpu_data_i = 32'hAABB_CCDD;
    step();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    host_txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat);
    check_val("merge_rdata", host_data_o, 32'h5566_CCDD);
    check_val("merge_ram", mem[16], 32'h5566_CCDD);
    host_req_i = 1'b0;
    step();

    // Same-cycle CPU write and host request: CPU commits first, host sees new data.
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h44; host_sel_i = 4'hF;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h44; cpu_sel_i = 4'hF;
    cpu_data_i = 32'h0BAD_F00D;
    step();
    check_val("same_cyc_no_ack", host_ack_o, 1'b0);
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    host_txn(1'b0, 32'h44, 32'h0, 4'hF, 1'b0, lat);
    check_val("same_cyc_lat", lat, 2);
    check_val("same_cyc_rdata", host_data_o, 32'h0BAD_F00D);
    host_req_i = 1'b0;
    step();

    // Reset in the middle of a host write slot drops the transaction.
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 32'h10; host_sel_i = 4'hF;
    host_data_i = 32'hDEAD_BEEF;
    cpu_ce_i = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_ram_ce", ram_ce_o, 1'b0);
    check_val("mid_rst_ram_we", ram_we_o, 1'b0);
    check_val("mid_rst_stall", cpu_stall_o, 1'b0);
    check_val("mid_rst_cpu_rdata", cpu_data_o, '0);
    check_val("mid_rst_host_rdata", host_data_o, '0);
    @(posedge clk);
    #1;
    check_val("mid_rst_no_ack", host_ack_o, 1'b0);
    check_val("mid_rst_ram_kept", mem[4], 32'hCAFE_0004);
    @(negedge clk);
    rst = 1'b0;
    host_req_i = 1'b0;
    model_reset();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    step();

    // Randomized traffic on both ports.
    h_busy = 1'b0;
    h_lat  = 0;
    for (int c = 0; c < 400; c++) begin
      if (!h_busy && $urandom_range(0, 2) == 0) begin
        h_busy      = 1'b1;
        h_lat       = 0;
        host_we_i   = 1'($urandom);
        host_addr_i = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
        host_data_i = $urandom;
        host_sel_i  = 4'($urandom_range(1, 15));
      end
      host_req_i = h_busy;
      cpu_ce_i   = ($urandom_range(0, 3) != 0);
      cpu_we_i   = 1'($urandom);
      cpu_addr_i = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
      cpu_sel_i  = 4'($urandom);
      cpu_data_i = $urandom;
      step();
      if (h_busy) h_lat++;
      if (h_busy && host_ack_o) begin
        check_val("rand_lat_bound", (h_lat <= MW + 2), 1'b1);
        h_busy = 1'b0;
      end else if (h_busy && h_lat > 30) begin
        check_val("rand_host_timeout", h_lat, MW + 2);
        h_busy = 1'b0;
      end
    end
    host_req_i = 1'b0;
    cpu_ce_i   = 1'b0;
    step();
    step();
    for (int i = 0; i < 16; i++) check_val("final_ram", mem[i], gmem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
